// File: rtl/sram_bus_walker.sv
// rtl/sram_bus_walker.sv - walking-one/zero pin tester for the SRAM bus and its transceivers
//
// Purpose:
//   Walks a single active bit across the concatenated pin vector
//   {ctrl, addr, data} (N = CTRL_W+ADDR_W+DATA_W bits). Each pattern is held
//   in DRIVE for HOLD_CYCLES cycles and then for one SAMPLE cycle, so one bit
//   takes HOLD_CYCLES+1 cycles and a sweep takes N*(HOLD_CYCLES+1) cycles.
//   Optional loopback checking is enabled by defining
//   SRAM_BUS_WALKER_LOOPBACK_EN; in the default build the *_in ports are
//   unused and the error outputs are tied to zero.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_start, i_stop             sweep start pulse, abort (stop has priority)
//   i_mode, i_continuous        0=walking-one/1=walking-zero, repeat sweeps
//   o_data_out/addr/ctrl_out    walked pins (ctrl = {n_write, n_oe, n_ce})
//   i_data_in/addr/ctrl_in      loopback fixture returns
//   o_trans_n_oe                transceiver enable, active-low
//   o_trans_tx_data/_addr       transceiver direction, 1 = transmit
//   o_busy, o_done              DRIVE/SAMPLE active, sweep-complete pulse
//   o_bit_index                 index of the active bit
//   o_sweep_count               completed sweeps (wrapping)
//   o_err_count                 loopback mismatches (saturating)
//   o_first_err_index           index of the first mismatch since start
//   o_led                       mirror of the data pins
module sram_bus_walker #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 15,
  parameter int CTRL_W      = 3,
  parameter int HOLD_CYCLES = 4,
  localparam int N          = DATA_W + ADDR_W + CTRL_W,
  localparam int IW         = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_mode,
  input  logic              i_continuous,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic [CTRL_W-1:0] i_ctrl_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic [ADDR_W-1:0] o_addr_out,
  output logic [CTRL_W-1:0] o_ctrl_out,
  output logic              o_trans_n_oe,
  output logic              o_trans_tx_data,
  output logic              o_trans_tx_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [IW-1:0]     o_bit_index,
  output logic [15:0]       o_sweep_count,
  output logic [15:0]       o_err_count,
  output logic [IW-1:0]     o_first_err_index,
  output logic [7:0]        o_led
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_mode;
  logic          r_cont;
  logic [HW-1:0] r_hold;
  logic [IW-1:0] r_bit_index;
  logic [15:0]   r_sweep_count;
  logic [N-1:0]  r_vec;
  logic          r_trans_n_oe;
  logic          r_busy;
  logic          r_done;

  // Single active bit on an all-zero background, inverted for walking-zero.
  function automatic logic [N-1:0] f_pattern(input logic [IW-1:0] idx, input logic m);
    logic [N-1:0] w;
    w = {{(N-1){1'b0}}, 1'b1} << idx;
    return m ? ~w : w;
  endfunction

`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
  logic [15:0]   r_err_count;
  logic [IW-1:0] r_first_err_index;
  logic          w_mismatch;

  assign w_mismatch        = ({i_ctrl_in, i_addr_in, i_data_in} != r_vec);
  assign o_err_count       = r_err_count;
  assign o_first_err_index = r_first_err_index;
`else
  logic w_unused_in;

  assign w_unused_in       = ^{i_ctrl_in, i_addr_in, i_data_in};
  assign o_err_count       = 16'd0;
  assign o_first_err_index = '0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_cont        <= 1'b0;
      r_hold        <= '0;
      r_bit_index   <= '0;
      r_sweep_count <= 16'd0;
      r_vec         <= '0;
      r_trans_n_oe  <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
      r_err_count       <= 16'd0;
      r_first_err_index <= '0;
`endif
    end else if (i_stop) begin
      // Abort from any state; counters keep their values for inspection.
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_vec        <= '0;
      r_trans_n_oe <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_mode        <= i_mode;
            r_cont        <= i_continuous;
            r_hold        <= '0;
            r_bit_index   <= '0;
            r_sweep_count <= 16'd0;
            // Pattern is loaded on the start edge so it reaches the pins
            // together with the DRIVE state.
            r_vec         <= f_pattern('0, i_mode);
            r_trans_n_oe  <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_DRIVE;
`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
            r_err_count       <= 16'd0;
            r_first_err_index <= '0;
`endif
          end
        end

        S_DRIVE: begin
          if (r_hold == HW'(HOLD_CYCLES - 1)) begin
            r_hold  <= '0;
            r_state <= S_SAMPLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        S_SAMPLE: begin
`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
          if (w_mismatch) begin
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (r_err_count == 16'd0) r_first_err_index <= r_bit_index;
          end
`endif
          if (r_bit_index == IW'(N - 1)) begin
            r_sweep_count <= r_sweep_count + 16'd1;
            r_bit_index   <= '0;
            if (r_cont) begin
              r_vec   <= f_pattern('0, r_mode);
              r_state <= S_DRIVE;
            end else begin
              r_vec        <= '0;
              r_trans_n_oe <= 1'b1;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= S_DONE;
            end
          end else begin
            r_bit_index <= r_bit_index + 1'b1;
            r_vec       <= f_pattern(r_bit_index + 1'b1, r_mode);
            r_state     <= S_DRIVE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_out      = r_vec[DATA_W-1:0];
  assign o_addr_out      = r_vec[DATA_W+ADDR_W-1:DATA_W];
  assign o_ctrl_out      = r_vec[N-1:DATA_W+ADDR_W];
  assign o_trans_n_oe    = r_trans_n_oe;
  // The tester only ever transmits towards the SRAM side.
  assign o_trans_tx_data = 1'b1;
  assign o_trans_tx_addr = 1'b1;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_bit_index     = r_bit_index;
  assign o_sweep_count   = r_sweep_count;
  assign o_led           = 8'(r_vec[DATA_W-1:0]);

endmodule

// File: tb/tb_sram_bus_walker.sv
// tb/tb_sram_bus_walker.sv - self-checking bench for sram_bus_walker
module tb_sram_bus_walker;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 15;
  localparam int CTRL_W = 3;
  localparam int HOLD   = 4;
  localparam int N      = DATA_W + ADDR_W + CTRL_W;
  localparam int IW     = $clog2(N);
  localparam int BITLEN = HOLD + 1;
  localparam int P      = N * BITLEN;

  logic clk = 1'b0;
  logic reset_n, start, stop, mode, continuous;
  logic [N-1:0] stuck0, stuck1, w_pins, w_loop;

  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic trans_n_oe, trans_tx_data, trans_tx_addr, busy, done;
  logic [IW-1:0] bit_index, first_err_index;
  logic [15:0] sweep_count, err_count;
  logic [7:0] led;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Loopback fixture: returns the pins with optional stuck-at-0/1 faults.
  assign w_pins = {ctrl_out, addr_out, data_out};
  assign w_loop = (w_pins & ~stuck0) | stuck1;

  sram_bus_walker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_stop(stop),
    .i_mode(mode), .i_continuous(continuous),
    .i_data_in(w_loop[DATA_W-1:0]),
    .i_addr_in(w_loop[DATA_W+ADDR_W-1:DATA_W]),
    .i_ctrl_in(w_loop[N-1:DATA_W+ADDR_W]),
    .o_data_out(data_out), .o_addr_out(addr_out), .o_ctrl_out(ctrl_out),
    .o_trans_n_oe(trans_n_oe), .o_trans_tx_data(trans_tx_data),
    .o_trans_tx_addr(trans_tx_addr), .o_busy(busy), .o_done(done),
    .o_bit_index(bit_index), .o_sweep_count(sweep_count),
    .o_err_count(err_count), .o_first_err_index(first_err_index), .o_led(led)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] pat(input logic m, input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return m ? ~v : v;
  endfunction

  // Expected loopback errors after n_samples compare points in mode m.
  task automatic model_err(input logic m, input int n_samples, output int e, output int f);
    logic [N-1:0] p;
    e = 0;
    f = 0;
`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
    for (int s = 0; s < n_samples; s++) begin
      p = pat(m, s % N);
      if (((p & ~stuck0) | stuck1) != p) begin
        if (e == 0) f = s % N;
        if (e < 65535) e++;
      end
    end
`endif
  endtask

  // One sweep (or continuous run) checked cycle by cycle. View t is the
  // settled state after the t-th edge following the start edge.
  // stop_t: view in which stop is raised (0 = none); restart_t: view in
  // which a spurious start is pulsed (0 = none).
  task automatic run(input logic m, input logic c, input int stop_t, input int restart_t);
    int last, idx, n_s, e, f;
    logic act, dn;
    logic [N-1:0] ev;
    mode = m; continuous = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; continuous = ~c;
    last = (stop_t > 0) ? stop_t + 2 : P + 2;
    for (int t = 1; t <= last; t++) begin
      act = c ? (t <= stop_t) : (t <= P && (stop_t == 0 || t <= stop_t));
      idx = ((t - 1) / BITLEN) % N;
      if (act) begin
        ev = pat(m, idx);
        check("vec", w_pins, ev);
        check("led", led, ev[7:0]);
        check("bit_index", bit_index, idx);
        check("busy", busy, 1);
        check("n_oe", trans_n_oe, 0);
        check("done", done, 0);
        check("sweep", sweep_count, (t - 1) / P);
        if (!m && idx == 8)  check("addr_b8", addr_out, 1);
        if (!m && idx == 25) check("ctrl_b25", ctrl_out, 3'b100);
        if (m && idx == 0)   check("data_z0", data_out, 8'hFE);
        if (m && idx == 10) begin
          check("addr_z10", addr_out, 15'h7FFB);
          check("data_z10", data_out, 8'hFF);
        end
      end else begin
        dn = !c && stop_t == 0 && t == P + 1;
        check("idle_vec", w_pins, 0);
        check("idle_n_oe", trans_n_oe, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, dn);
        check("idle_sweep", sweep_count, (stop_t > 0) ? (stop_t - 1) / P : 1);
        if (stop_t == 0) check("idle_bit_index", bit_index, 0);
      end
      check("tx_dir", {trans_tx_data, trans_tx_addr}, 2'b11);
      stop  = (t == stop_t);
      start = (t == restart_t);
      @(posedge clk); #1;
    end
    stop = 1'b0; start = 1'b0;
    n_s = (stop_t > 0) ? (stop_t - 1) / BITLEN : N;
    if (!c && n_s > N) n_s = N;
    model_err(m, n_s, e, f);
    check("err_count", err_count, e);
    check("first_err", first_err_index, f);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, a, b;
    logic m;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; continuous = 1'b0;
    stuck0 = '0; stuck1 = '0;

    // Reset values.
    @(posedge clk); @(posedge clk); #1;
    check("rst_vec", w_pins, 0);
    check("rst_n_oe", trans_n_oe, 1);
    check("rst_tx", {trans_tx_data, trans_tx_addr}, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit", bit_index, 0);
    check("rst_sweep", sweep_count, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_index, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy0", busy, 0);

    // Walking-one single sweep with a spurious start while busy.
    r = $urandom_range(2, P - 1);
    run(1'b0, 1'b0, 0, r);

    // Stuck-at-0 on addr_in[3] (vector bit 11), both modes.
    stuck0 = '0; stuck0[11] = 1'b1;
    run(1'b0, 1'b0, 0, 0);
`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
    check("lb_err_m0", err_count, 1);
    check("lb_first_m0", first_err_index, 11);
`endif
    run(1'b1, 1'b0, 0, 0);
`ifdef SRAM_BUS_WALKER_LOOPBACK_EN
    check("lb_err_m1", err_count, 25);
    check("lb_first_m1", first_err_index, 0);
`endif

    // Random fixture faults and random mode.
    a = $urandom_range(0, N - 1);
    b = (a + $urandom_range(1, N - 1)) % N;
    stuck0 = '0; stuck1 = '0;
    stuck0[a] = 1'b1;
    stuck1[b] = 1'b1;
    m = 1'($urandom_range(0, 1));
    run(m, 1'b0, 0, 0);
    stuck0 = '0; stuck1 = '0;

    // Continuous for three sweeps, stopped in view 400.
    m = 1'($urandom_range(0, 1));
    run(m, 1'b1, 400, $urandom_range(10, 300));
    check("cont_sweep3", sweep_count, 3);

    // Random abort point, random continuity.
    m = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1) run(m, 1'b1, $urandom_range(3, 2 * P), 0);
    else run(m, 1'b0, $urandom_range(3, P - 1), 0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_vec", w_pins, 0);
    check("ss_n_oe", trans_n_oe, 1);
    @(posedge clk); #1;
    check("ss_busy2", busy, 0);

    // Asynchronous reset at bit_index 12.
    mode = 1'b0; continuous = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t < 12 * BITLEN + 1; t++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_bit", bit_index, 12);
    check("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_vec", w_pins, 0);
    check("arst_n_oe", trans_n_oe, 1);
    check("arst_busy", busy, 0);
    check("arst_bit", bit_index, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_vec", w_pins, 0);
    check("post_rst_n_oe", trans_n_oe, 1);
    check("post_rst_sweep", sweep_count, 0);
    check("post_rst_err", err_count, 0);
    check("post_rst_bit", bit_index, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_walker.md
Name: sram_bus_walker

Overview:
Parametrised board-level pin tester for the SRAM bus and its transceivers. It walks a single active bit, either walking-one or walking-zero, across every data, address and control pin. All three groups are treated as one concatenated vector, and each bit is held for a programmable number of cycles. The block is driven by start/stop, reports sweep progress, and can optionally check a loopback fixture. It sits at top level between the board pins and a status/LED front end.

Parameters:
DATA_W, 8, SRAM data pin count
ADDR_W, 15, SRAM address pin count
CTRL_W, 3, control pin count; bit order {n_write, n_oe, n_ce} MSB..LSB
HOLD_CYCLES, 4, cycles each pattern is held in DRIVE (>=1)
N (localparam), DATA_W+ADDR_W+CTRL_W, total walked pins; IW = clog2(N)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep when idle
stop  in  1  abort; takes priority over all other inputs
mode  in  1  0 = walking-one, 1 = walking-zero; latched on start
continuous  in  1  1 = repeat sweeps until stop; latched on start
data_out  out  DATA_W  data pins = vec[DATA_W-1:0]
addr_out  out  ADDR_W  address pins = vec[DATA_W+ADDR_W-1:DATA_W]
ctrl_out  out  CTRL_W  control pins = vec[N-1:DATA_W+ADDR_W]
data_in / addr_in / ctrl_in  in  DATA_W/ADDR_W/CTRL_W  loopback fixture returns
trans_n_oe  out  1  transceiver enable, active-low
trans_tx_data, trans_tx_addr  out  1  transceiver direction; 1 = transmit
busy  out  1  high in DRIVE/SAMPLE
done  out  1  one-cycle pulse when a non-continuous sweep completes
bit_index  out  IW  index of the currently active bit
sweep_count  out  16  completed sweeps, wraps at 0xFFFF→0
err_count  out  16  mismatches, saturating
first_err_index  out  IW  index of the first mismatch since start
led  out  8  = data_out

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; all pin outputs 0; trans_n_oe=1; trans_tx_*=1.
  - busy=0, done=0; bit_index, sweep_count, err_count, first_err_index = 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - vec=0; trans_n_oe=1.
  - On start: latch mode and continuous; clear sweep_count, err_count, first_err_index and bit_index; go to DRIVE on the next edge.
- DRIVE:
  - trans_n_oe=0.
  - vec = (1<<bit_index), inverted when mode=1.
  - Hold counter runs 0..HOLD_CYCLES-1, then → SAMPLE.
- SAMPLE (1 cycle, pattern still driven):
  - Loopback compare is performed here (see Optional Feature).
  - If bit_index<N-1: bit_index++, → DRIVE.
  - If bit_index==N-1: sweep_count++, bit_index=0; → DRIVE when continuous=1, else → DONE.
- DONE (1 cycle): done=1, vec=0, trans_n_oe=1; → IDLE.
- Timing: each bit occupies HOLD_CYCLES+1 cycles, so one sweep takes N*(HOLD_CYCLES+1) cycles. The first pattern appears on the pins 1 cycle after start.
- busy is registered and aligned with the DRIVE/SAMPLE states.
- start is ignored while busy or in DONE.
- stop in any state: → IDLE on the next edge; vec=0, trans_n_oe=1, no done pulse. Counters hold their values until the next start.
- start and stop in the same cycle: stop wins, and the block stays IDLE.
- Exactly one bit of vec differs from the background at any time. There are no wrap artefacts between groups; the address group walks fully to its MSB.
- reset_n asserted mid-sweep: immediate return to reset values, with transceivers disabled combinationally with the state.

Optional Feature:
- Macro: SRAM_BUS_WALKER_LOOPBACK_EN.
- Defined: in SAMPLE, compare {ctrl_in,addr_in,data_in} against vec.
  - On mismatch: err_count saturating-increments.
  - If err_count was 0 before this cycle, first_err_index = bit_index.
- Not defined:
  - No compare logic is built; *_in ports are unused.
  - err_count and first_err_index are tied to 0.

Test Plan (defaults, N=26, HOLD_CYCLES=4):
- start, mode=0, continuous=0 → vec=0x0000001 for 5 cycles, then 0x0000002 …; addr_out=0x0001 while bit_index=8; ctrl_out=3'b100 while bit_index=25; done pulses at cycle 131 after start; sweep_count=1; trans_n_oe=1 afterwards.
- mode=1 → data_out=8'hFE at the first pattern; at bit_index=10, addr_out=15'h7FFB and data_out=8'hFF.
- continuous=1 for 3 sweeps, then stop at cycle 400 → sweep_count=3; all outputs 0 and trans_n_oe=1 by cycle 401; no done pulse.
- start and stop asserted together in IDLE → stays IDLE, busy=0; start while busy → no restart and bit_index unaffected.
- reset_n low at bit_index=12 → outputs 0 and trans_n_oe=1 immediately; after release the block is IDLE with all counters 0.
- LOOPBACK_EN with a fixture where addr_in[3] is stuck at 0, mode=0, one sweep → err_count=1, first_err_index=11; repeat with mode=1 → err_count=25, first_err_index=0.
